adc_spi_reader: RTL and testbench
=================================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 Parameter WIDTH, default 12, number of sample data bits per conversion.
REQ-002 Parameter CLK_DIV, default 2, clk cycles per adc_sclk half-period; legal values are 1 or greater.
REQ-003 Parameter QUIET, default 2, minimum adc_cs-high time between conversions, in adc_sclk periods; legal values are 1 or greater.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request for one conversion.
REQ-007 cont  input  1  level; while high, conversions repeat back-to-back.
REQ-008 adc_cs  output  1  ADC chip select, active low.
REQ-009 adc_sclk  output  1  ADC serial clock, idle high.
REQ-010 adc_sd  input  1  ADC serial data.
REQ-011 sample  output  WIDTH  last completed conversion, MSB first on the wire.
REQ-012 sample_valid  output  1  single-cycle strobe: sample has just been updated.
REQ-013 busy  output  1  high in CONVERT and QUIET.

Function
REQ-014 FSM states: IDLE, CONVERT, QUIET.
REQ-015 IDLE: adc_cs=1, adc_sclk=1; start or cont seen at a clk edge -> CONVERT on the next edge, with adc_cs=0.
REQ-016 CONVERT: a frame is WIDTH+1 adc_sclk periods; each period drives adc_sclk low for CLK_DIV clk cycles, then high for CLK_DIV clk cycles.
REQ-017 adc_sd is captured on the clk edge at which adc_sclk goes from low to high.
REQ-018 Capture 0 is the ADC's leading zero and is discarded; captures 1..WIDTH are shifted in MSB first.
REQ-019 At the end of the final high half-period: adc_cs=1, sample is loaded, and sample_valid=1 for exactly one cycle; then -> QUIET.
REQ-020 Latency from start to sample_valid is 1 + 2*CLK_DIV*(WIDTH+1) clk cycles.
REQ-021 QUIET: adc_cs=1 and adc_sclk=1 for QUIET*2*CLK_DIV cycles; then -> CONVERT if cont=1, else -> IDLE.
REQ-022 start asserted in CONVERT or QUIET is ignored and is not queued.
REQ-023 cont deasserted mid-frame: the current frame completes normally, then the block returns to IDLE after QUIET.
REQ-024 sample holds its value between strobes; the shift register does not alter sample mid-frame.
REQ-025 adc_sd is treated as synchronous to clk, with no synchronizer.

Reset
REQ-026 While reset_n=0: state=IDLE, adc_cs=1, adc_sclk=1, sample=0, sample_valid=0, busy=0, and all counters are 0.
REQ-027 Reset asserted mid-frame aborts the frame immediately, asynchronously, with no sample_valid strobe.
REQ-028 The first conversion after reset release requires a new start or cont.

Configuration
REQ-029 Macro ADC_SPI_READER_FRAME_CHECK_EN defined: an output frame_err (1 bit) is added.
REQ-030 With the macro, frame_err is loaded together with sample and is 1 when capture 0 was nonzero; sample is still updated.
REQ-031 With the macro, frame_err resets to 0.
REQ-032 Macro undefined: there is no frame_err port and no check logic.

Structure
REQ-033 A shared package adc_pkg holds the state enum and the default WIDTH, CLK_DIV and QUIET constants.
REQ-034 A sub-module adc_sclk_gen produces the half-period tick and adc_sclk; the FSM, bit counter and shift register stay in the top level.

Verification
REQ-035 Bench uses the ADC model with HIGH=200, WIDTH=12, CLK_DIV=2, single start -> sample=200 (0x0C8), one sample_valid at cycle 53 after start.
REQ-036 Bench holds cont=1 across a model HIGH/LOW toggle -> alternating samples 200 and 0; adc_cs high for at least 8 clk cycles between frames.
REQ-037 Bench asserts reset_n=0 at capture 6 -> adc_cs=1 and adc_sclk=1 in the same cycle, no strobe, IDLE after release.
REQ-038 Bench pulses start again at capture 4 and during QUIET -> exactly one frame occurs.
REQ-039 Bench forces adc_sd=1 during capture 0 with ADC_SPI_READER_FRAME_CHECK_EN defined -> frame_err=1 with the strobe; a clean frame -> frame_err=0.
REQ-040 Bench uses CLK_DIV=1, QUIET=1, all-ones data -> sample=0xFFF; adc_sclk period of 2 clk cycles.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adc_pkg
//  Purpose : Shared definitions for the ADC SPI reader: FSM state encoding,
//            default parameter values and a counter-width helper.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package adc_pkg;

   localparam int ADC_WIDTH_DEF   = 12;
   localparam int ADC_CLK_DIV_DEF = 2;
   localparam int ADC_QUIET_DEF   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_QUIET   = 2'd2
   } adc_state_t;

   // Width of a counter that must hold values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module  : adc_sclk_gen
//  Purpose : Serial-clock generator for the ADC reader. Divides clk into
//            half-periods of CLK_DIV cycles and toggles adc_sclk at the end
//            of each half-period while a frame is running.
//  Ports   : clk, reset_n   - clock, asynchronous active-low reset
//            launch         - first cycle of a frame: drive sclk low, restart
//            run            - a frame is in progress
//            stop           - frame ends this cycle: park sclk high
//            tick           - last clk cycle of the current half-period
//            sclk           - serial clock, idle high
//  Revision: 1.0  initial release
// ============================================================================
module adc_sclk_gen
   import adc_pkg::*;
#(
   parameter int CLK_DIV = ADC_CLK_DIV_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic launch,
   input  logic run,
   input  logic stop,
   output logic tick,
   output logic sclk
);

   localparam int            CW       = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   // tick depends only on run and the divider, never on stop, so the top
   // level can derive stop from tick without a combinational loop.
   assign tick = run && (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         sclk    <= 1'b1;
      end else if (launch) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (!run || stop) begin
         div_cnt <= '0;
         sclk    <= 1'b1;
      end else if (tick) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule : adc_sclk_gen
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module  : adc_spi_reader
//  Purpose : Reads WIDTH-bit conversions from a serial ADC. A frame is
//            WIDTH+1 sclk periods; the first captured bit is the ADC's
//            leading zero and is dropped, the rest are shifted in MSB first.
//            Single conversions on start, back-to-back while cont is high,
//            with a QUIET sclk-period chip-select-high gap after each frame.
//  Ports   : clk, reset_n        - clock, asynchronous active-low reset
//            start, cont         - single request / continuous level
//            adc_cs, adc_sclk    - ADC chip select (low), serial clock (idle hi)
//            adc_sd              - ADC serial data (clk-synchronous)
//            sample, sample_valid- last conversion and its update strobe
//            busy                - frame or quiet gap in progress
//            frame_err           - leading bit was nonzero (optional)
//  Config  : define ADC_SPI_READER_FRAME_CHECK_EN to add frame_err.
//  Revision: 1.0  initial release
// ============================================================================
module adc_spi_reader
   import adc_pkg::*;
#(
   parameter int WIDTH   = ADC_WIDTH_DEF,
   parameter int CLK_DIV = ADC_CLK_DIV_DEF,
   parameter int QUIET   = ADC_QUIET_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             cont,
   output logic             adc_cs,
   output logic             adc_sclk,
   input  logic             adc_sd,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   output logic             busy
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
   ,
   output logic             frame_err
`endif
);

   // Bit counter runs 0..WIDTH+1: captures 0..WIDTH, then "all captured".
   localparam int            BW       = cnt_width(WIDTH + 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH + 1);

   localparam int            QCYC     = QUIET * 2 * CLK_DIV;
   localparam int            QW       = cnt_width(QCYC);
   localparam logic [QW-1:0] Q_LAST   = QW'(QCYC - 1);

   adc_state_t       state;
   adc_state_t       state_next;
   logic             launch;
   logic             capture;
   logic             frame_done;
   logic             tick;
   logic [BW-1:0]    bit_cnt;
   logic [QW-1:0]    q_cnt;
   logic [WIDTH-1:0] shreg;

   adc_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .launch  (launch),
      .run     (state == ST_CONVERT),
      .stop    (frame_done),
      .tick    (tick),
      .sclk    (adc_sclk)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and frame control strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      capture    = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start || cont) begin
               state_next = ST_CONVERT;
               launch     = 1'b1;
            end
         end
         ST_CONVERT: begin
            // sclk rises at the end of a low half: that is the capture edge.
            capture = tick && !adc_sclk;
            // End of the high half after the last capture closes the frame.
            if (tick && adc_sclk && (bit_cnt == BIT_LAST)) begin
               frame_done = 1'b1;
               state_next = ST_QUIET;
            end
         end
         ST_QUIET: begin
            if (q_cnt == Q_LAST) begin
               if (cont) begin
                  state_next = ST_CONVERT;
                  launch     = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs follow the next state so they change on the same
   // edge as the state itself.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         adc_cs       <= 1'b1;
         busy         <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         adc_cs       <= (state_next != ST_CONVERT);
         busy         <= (state_next != ST_IDLE);
         sample_valid <= frame_done;
      end
   end

   // ------------------------------------------------------------------
   // Bit counter and shift register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (launch) begin
         bit_cnt <= '0;
      end else if (capture) begin
         bit_cnt <= bit_cnt + BW'(1);
         // Capture 0 is the leading zero and never enters the data.
         if (bit_cnt != '0) begin
            shreg <= WIDTH'({shreg, adc_sd});
         end
      end
   end

   // sample is only touched at frame end, so it holds between strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample <= '0;
      end else if (frame_done) begin
         sample <= shreg;
      end
   end

   // ------------------------------------------------------------------
   // Quiet-gap counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_cnt <= '0;
      end else if ((state == ST_QUIET) && (q_cnt != Q_LAST)) begin
         q_cnt <= q_cnt + QW'(1);
      end else begin
         q_cnt <= '0;
      end
   end

`ifdef ADC_SPI_READER_FRAME_CHECK_EN
   // ------------------------------------------------------------------
   // Leading-bit check: remember capture 0, publish it with the sample.
   // ------------------------------------------------------------------
   logic lead_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lead_bit  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (capture && (bit_cnt == '0)) begin
            lead_bit <= adc_sd;
         end
         if (frame_done) begin
            frame_err <= lead_bit;
         end
      end
   end
`endif

endmodule : adc_spi_reader
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adc_spi_reader
//  Purpose : Directed self-checking bench for adc_spi_reader. Two instances:
//            WIDTH=12/CLK_DIV=2/QUIET=2 and WIDTH=12/CLK_DIV=1/QUIET=1, each
//            fed by a small ADC model (leading bit, then data MSB first).
//  Config  : frame_err checks are built when ADC_SPI_READER_FRAME_CHECK_EN
//            is defined.
//  Revision: 1.0  initial release
// ============================================================================
module tb_adc_spi_reader;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start, cont, start2;
   logic         adc_cs, adc_sclk, adc_sd, sample_valid, busy;
   logic [W-1:0] sample;
   logic         adc_cs2, adc_sclk2, adc_sd2, sample_valid2, busy2;
   logic [W-1:0] sample2;
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
   logic         frame_err, frame_err2;
`endif

   int checks   = 0;
   int failures = 0;
   int strobes  = 0;
   int strobes2 = 0;

   always #5 clk = ~clk;

   adc_spi_reader #(.WIDTH(W), .CLK_DIV(2), .QUIET(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .cont         (cont),
      .adc_cs       (adc_cs),
      .adc_sclk     (adc_sclk),
      .adc_sd       (adc_sd),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy)
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
      ,
      .frame_err    (frame_err)
`endif
   );

   adc_spi_reader #(.WIDTH(W), .CLK_DIV(1), .QUIET(1)) dut2 (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start2),
      .cont         (1'b0),
      .adc_cs       (adc_cs2),
      .adc_sclk     (adc_sclk2),
      .adc_sd       (adc_sd2),
      .sample       (sample2),
      .sample_valid (sample_valid2),
      .busy         (busy2)
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
      ,
      .frame_err    (frame_err2)
`endif
   );

   // ADC models: preload {lead, value} while cs is high, advance one bit
   // after every sclk rise (observed on the falling clk edge).
   logic [W:0]   m_sr, m_sr2;
   logic         m_prev, m_prev2;
   logic [W-1:0] model_val;
   logic         force_lead;

   assign adc_sd  = m_sr[W];
   assign adc_sd2 = m_sr2[W];

   always @(negedge clk) begin
      if (adc_cs)                   m_sr <= {force_lead, model_val};
      else if (adc_sclk && !m_prev) m_sr <= {m_sr[W-1:0], 1'b0};
      m_prev <= adc_sclk;
      if (adc_cs2)                    m_sr2 <= {1'b0, 12'hFFF};
      else if (adc_sclk2 && !m_prev2) m_sr2 <= {m_sr2[W-1:0], 1'b0};
      m_prev2 <= adc_sclk2;
      if (sample_valid)  strobes  <= strobes + 1;
      if (sample_valid2) strobes2 <= strobes2 + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         step();
         n = n + 1;
         if (sample_valid) break;
      end
   endtask

   task automatic wait_rises(input int target, output int rises);
      logic prev;
      prev  = adc_sclk;
      rises = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (adc_sclk && !prev) rises = rises + 1;
         prev = adc_sclk;
         if (rises == target) break;
      end
   endtask

   initial begin
      int n, hc, s0, rises, r1, r2;
      logic prev;
      reset_n    = 1'b0;
      start      = 1'b0;
      cont       = 1'b0;
      start2     = 1'b0;
      model_val  = 12'd200;
      force_lead = 1'b0;
      repeat (3) step();

      // Reset state
      check_val("rst_cs",    32'(adc_cs),       32'd1);
      check_val("rst_sclk",  32'(adc_sclk),     32'd1);
      check_val("rst_sample",32'(sample),       32'd0);
      check_val("rst_valid", 32'(sample_valid), 32'd0);
      check_val("rst_busy",  32'(busy),         32'd0);
      check_val("rst_cs2",   32'(adc_cs2),      32'd1);
      reset_n = 1'b1;
      repeat (4) step();
      check_val("idle_no_conv", 32'(busy), 32'd0);

      // Single conversion, latency 53
      s0 = strobes;
      pulse_start();
      wait_valid(100, n);
      check_val("lat_single", 32'(1 + n), 32'd53);
      check_val("sample_200", 32'(sample), 32'd200);
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
      check_val("ferr_clean", 32'(frame_err), 32'd0);
`endif
      repeat (3) step();
      check_val("busy_quiet", 32'(busy), 32'd1);
      check_val("cs_quiet",   32'(adc_cs), 32'd1);
      repeat (10) step();
      check_val("one_strobe", 32'(strobes - s0), 32'd1);
      check_val("idle_after", 32'(busy), 32'd0);
      check_val("hold_200",   32'(sample), 32'd200);

      // Continuous mode with HIGH/LOW toggle
      cont = 1'b1;
      wait_valid(100, n);
      check_val("cont_s1", 32'(sample), 32'd200);
      model_val = 12'd0;
      hc = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!adc_cs) break;
         hc = hc + 1;
      end
      check_val("cs_gap", 32'(hc), 32'd8);
      wait_valid(100, n);
      check_val("cont_s2", 32'(sample), 32'd0);
      model_val = 12'd200;
      wait_valid(100, n);
      check_val("cont_s3", 32'(sample), 32'd200);
      model_val = 12'd0;
      repeat (20) step();
      cont = 1'b0;
      wait_valid(100, n);
      check_val("cont_last", 32'(sample), 32'd0);
      repeat (15) step();
      s0 = strobes;
      check_val("cont_idle", 32'(busy), 32'd0);
      repeat (60) step();
      check_val("cont_stop", 32'(strobes - s0), 32'd0);

      // Reset during capture 6
      model_val = 12'd200;
      pulse_start();
      wait_rises(7, rises);
      check_val("reach_cap6", 32'(rises), 32'd7);
      s0 = strobes;
      #2 reset_n = 1'b0;
      #1;
      check_val("abort_cs",   32'(adc_cs),   32'd1);
      check_val("abort_sclk", 32'(adc_sclk), 32'd1);
      check_val("abort_busy", 32'(busy),     32'd0);
      check_val("abort_samp", 32'(sample),   32'd0);
      repeat (5) step();
      reset_n = 1'b1;
      repeat (60) step();
      check_val("abort_nostrobe", 32'(strobes - s0), 32'd0);
      check_val("abort_idle",     32'(busy),         32'd0);
      check_val("abort_idle_cs",  32'(adc_cs),       32'd1);

      // start ignored during CONVERT and QUIET
      s0 = strobes;
      pulse_start();
      wait_rises(5, rises);
      pulse_start();
      wait_valid(100, n);
      check_val("ign_sample", 32'(sample), 32'd200);
      repeat (3) step();
      pulse_start();
      repeat (80) step();
      check_val("ign_one_frame", 32'(strobes - s0), 32'd1);
      check_val("ign_idle",      32'(busy),         32'd0);

`ifdef ADC_SPI_READER_FRAME_CHECK_EN
      // Leading-bit check
      force_lead = 1'b1;
      pulse_start();
      wait_valid(100, n);
      check_val("ferr_set",    32'(frame_err), 32'd1);
      check_val("ferr_sample", 32'(sample),    32'd200);
      force_lead = 1'b0;
      repeat (15) step();
      pulse_start();
      wait_valid(100, n);
      check_val("ferr_clear",  32'(frame_err), 32'd0);
      repeat (15) step();
`endif

      // CLK_DIV=1, QUIET=1, all-ones data
      s0 = strobes2;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      n = 1; r1 = 0; r2 = 0;
      prev = adc_sclk2;
      while (n < 100) begin
         step();
         n = n + 1;
         if (adc_sclk2 && !prev) begin
            if (r1 == 0)      r1 = n;
            else if (r2 == 0) r2 = n;
         end
         prev = adc_sclk2;
         if (sample_valid2) break;
      end
      check_val("div1_lat",    32'(n),       32'd27);
      check_val("div1_period", 32'(r2 - r1), 32'd2);
      check_val("div1_sample", 32'(sample2), 32'hFFF);
`ifdef ADC_SPI_READER_FRAME_CHECK_EN
      check_val("div1_ferr",   32'(frame_err2), 32'd0);
`endif
      repeat (10) step();
      check_val("div1_strobes", 32'(strobes2 - s0), 32'd1);
      check_val("div1_idle",    32'(busy2),         32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_adc_spi_reader
`default_nettype wire
